// File: rtl/read_bmp_pkg.sv
// -----------------------------------------------------------------------------
// read_bmp_pkg -- shared video package.
// Holds the frame geometry, the coordinate/address/pixel widths, the readback
// state enum and the rectangle helpers. The write-side placement block imports
// the same package, so both sides use one definition of the frame.
// -----------------------------------------------------------------------------
package read_bmp_pkg;

  localparam int VID_W  = 640;
  localparam int VID_H  = 480;
  localparam int ADDR_W = 19;
  localparam int PIX_W  = 9;
  localparam int X_W    = 10;
  localparam int Y_W    = 9;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [PIX_W-1:0]  pix_t;
  typedef logic [X_W-1:0]    xcoord_t;
  typedef logic [Y_W-1:0]    ycoord_t;
  typedef logic [X_W:0]      xend_t;   // one bit wider so xloc+xwid cannot wrap
  typedef logic [Y_W:0]      yend_t;   // one bit wider so yloc+ywid cannot wrap

  typedef enum logic [1:0] {IDLE, CHK, RD, DRAIN} rd_state_e;

  typedef struct packed {
    xcoord_t xloc;
    ycoord_t yloc;
    xcoord_t xwid;
    ycoord_t ywid;
  } rect_t;

  // A rectangle is legal when it is non-empty and lies entirely inside the frame.
  function automatic logic rect_legal(input rect_t r);
    xend_t x_end;
    yend_t y_end;
    x_end = {1'b0, r.xloc} + {1'b0, r.xwid};
    y_end = {1'b0, r.yloc} + {1'b0, r.ywid};
    return (r.xwid != '0) && (r.ywid != '0) &&
           (x_end <= xend_t'(VID_W)) && (y_end <= yend_t'(VID_H));
  endfunction

  // Linear address of the top-left pixel: row*640+col.
  function automatic addr_t rect_base(input rect_t r);
    return addr_t'(r.yloc) * addr_t'(VID_W) + addr_t'(r.xloc);
  endfunction

endpackage

// File: rtl/read_bmp_if.sv
// -----------------------------------------------------------------------------
// read_bmp_if -- bundle of the readback request, videoMem read port and pixel
// stream.
//   request : start, xloc, yloc, xwid, ywid          (master -> slave)
//   status  : busy, done, err                        (slave  -> master)
//   memory  : raddr, re (slave -> master), rdata (master -> slave, 1-cycle lat.)
//   stream  : pix, pix_vld (slave -> master), pix_rdy (master -> slave)
// The slave modport is the read_bmp block; the master is its environment.
// -----------------------------------------------------------------------------
interface read_bmp_if;
  import read_bmp_pkg::*;

  logic    start;
  xcoord_t xloc;
  ycoord_t yloc;
  xcoord_t xwid;
  ycoord_t ywid;
  addr_t   raddr;
  logic    re;
  pix_t    rdata;
  pix_t    pix;
  logic    pix_vld;
  logic    pix_rdy;
  logic    busy;
  logic    done;
  logic    err;

  modport slave (
    input  start, xloc, yloc, xwid, ywid, rdata, pix_rdy,
    output raddr, re, pix, pix_vld, busy, done, err
  );

  modport master (
    output start, xloc, yloc, xwid, ywid, rdata, pix_rdy,
    input  raddr, re, pix, pix_vld, busy, done, err
  );

endinterface

// File: rtl/read_bmp_pix_fifo2.sv
// -----------------------------------------------------------------------------
// pix_fifo2 -- 2-entry, 9-bit first-in first-out buffer for returned pixels.
//   clk, rst_n : clock, asynchronous active-low reset (flushes the buffer)
//   push, din  : write din this cycle
//   pop        : drop the head entry this cycle (caller guarantees !empty)
//   dout       : head entry (reads 0 after reset)
//   empty      : no entries
//   count      : number of entries (0..2)
// The caller never pushes when full; a simultaneous push and pop keeps the
// count and order unchanged.
// -----------------------------------------------------------------------------
module pix_fifo2
  import read_bmp_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  pix_t       din,
  input  logic       pop,
  output pix_t       dout,
  output logic       empty,
  output logic [1:0] count
);

  pix_t mem [2];
  logic wr_ptr;
  logic rd_ptr;

  // NOTE: the two storage words are reset along with the pointers so that dout
  // (and therefore pix) reads a defined 0 out of reset; a deeper RAM would
  // normally be left unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign empty = (count == 2'd0);

endmodule

// File: rtl/read_bmp.sv
// -----------------------------------------------------------------------------
// read_bmp -- reads a rectangle back out of videoMem and streams its pixels in
// raster order (left-to-right, top-to-bottom).
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   bus        : read_bmp_if.slave
//     start/xloc/yloc/xwid/ywid : request, sampled only in IDLE
//     raddr/re/rdata            : videoMem read port, rdata one cycle after re
//     pix/pix_vld/pix_rdy       : pixel stream, transfer on pix_vld & pix_rdy
//     busy/done/err             : status; done and err are one-cycle pulses
// Flow control: re is raised only while the pixels already owned (FIFO entries
// left after this cycle's pop plus the rdata landing this cycle) number at most
// one, so the 2-entry FIFO can never overflow yet streams one pixel per cycle.
// -----------------------------------------------------------------------------
module read_bmp
  import read_bmp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  read_bmp_if.slave   bus
);

  rd_state_e  state;
  rect_t      rect_q;
  xcoord_t    col_cnt;     // columns left in the current row, incl. this one
  ycoord_t    row_cnt;     // rows left, incl. the current one
  logic       re_d;        // a read was issued last cycle: rdata is valid now
  logic       pop;
  logic       credit_ok;
  logic       last_rd;
  logic       fifo_empty;
  logic [1:0] fifo_cnt;
  pix_t       fifo_dout;

  assign pop       = !fifo_empty && bus.pix_rdy;
  assign credit_ok = ({1'b0, fifo_cnt} + {2'b00, re_d} - {2'b00, pop}) <= 3'd1;
  assign last_rd   = (col_cnt == xcoord_t'(1)) && (row_cnt == ycoord_t'(1));

  // re looks at this cycle's pop so a steady stream never stalls.
  assign bus.re      = (state == RD) && credit_ok;
  assign bus.pix_vld = !fifo_empty;
  assign bus.pix     = fifo_dout;

  // NOTE: every register here is updated with <= so all of them sample the
  // pre-edge values; a blocking = would let later statements see new values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rect_q    <= '0;
      col_cnt   <= '0;
      row_cnt   <= '0;
      bus.raddr <= '0;
      re_d      <= 1'b0;    // also drops rdata from any read issued before reset
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
      bus.err   <= 1'b0;
    end else begin
      re_d     <= bus.re;
      bus.done <= 1'b0;
      bus.err  <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            rect_q   <= '{xloc: bus.xloc, yloc: bus.yloc,
                          xwid: bus.xwid, ywid: bus.ywid};
            bus.busy <= 1'b1;
            state    <= CHK;
          end
        end
        CHK: begin
          if (rect_legal(rect_q)) begin
            bus.raddr <= rect_base(rect_q);
            col_cnt   <= rect_q.xwid;
            row_cnt   <= rect_q.ywid;
            state     <= RD;
          end else begin
            bus.err  <= 1'b1;
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
        end
        RD: begin
          if (bus.re) begin
            if (last_rd) begin
              state <= DRAIN;
            end else if (col_cnt == xcoord_t'(1)) begin
              // Wrap to the first column of the next row.
              bus.raddr <= bus.raddr + addr_t'(VID_W + 1) - addr_t'(rect_q.xwid);
              col_cnt   <= rect_q.xwid;
              row_cnt   <= row_cnt - ycoord_t'(1);
            end else begin
              bus.raddr <= bus.raddr + addr_t'(1);
              col_cnt   <= col_cnt - xcoord_t'(1);
            end
          end
        end
        DRAIN: begin
          // Final handshake: the last buffered pixel leaves and nothing is in flight.
          if (pop && (fifo_cnt == 2'd1) && !re_d) begin
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  pix_fifo2 u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (re_d),
    .din   (bus.rdata),
    .pop   (pop),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

endmodule

// File: tb/tb_read_bmp.sv
// -----------------------------------------------------------------------------
// tb_read_bmp -- self-checking bench for read_bmp.
// A videoMem model answers every re one cycle later with a pixel derived from
// the address. For each request the expected read addresses and pixels are
// built from the rectangle with nested row/column loops; monitors capture what
// the block actually did and the main sequence compares the two.
// -----------------------------------------------------------------------------
module tb_read_bmp;
  import read_bmp_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  read_bmp_if bus ();

  read_bmp dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- videoMem model ----------------
  function automatic pix_t pix_of(input int addr);
    return pix_t'((addr * 37) ^ (addr >> 9));
  endfunction

  logic  mem_pend = 1'b0;
  addr_t mem_addr = '0;

  always @(negedge clk) begin
    mem_pend = bus.re;
    mem_addr = bus.raddr;
  end

  always @(posedge clk) begin
    #1;
    bus.rdata = mem_pend ? pix_of(int'(mem_addr)) : pix_t'($urandom);
  end

  // ---------------- consumer ready driver ----------------
  int rdy_mode   = 0;   // 0: always ready, 1: random, 2: stalled for stall_left cycles
  int stall_left = 0;

  initial begin
    bus.pix_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1:       bus.pix_rdy = 1'($urandom_range(0, 1));
        2: begin
          if (stall_left > 0) begin
            bus.pix_rdy = 1'b0;
            stall_left--;
          end else begin
            bus.pix_rdy = 1'b1;
          end
        end
        default: bus.pix_rdy = 1'b1;
      endcase
    end
  end

  // ---------------- monitor ----------------
  int   got_addr[$];
  int   re_cyc[$];
  int   got_pix[$];
  int   hs_cyc[$];
  int   done_n, err_n, done_cyc, err_cyc, stall_re;
  logic busy_at_done, busy_at_err;
  logic prev_stall = 1'b0;
  pix_t prev_pix   = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.re) begin
        got_addr.push_back(int'(bus.raddr));
        re_cyc.push_back(cyc);
        if (!bus.pix_rdy) stall_re++;
      end
      if (bus.pix_vld && bus.pix_rdy) begin
        got_pix.push_back(int'(bus.pix));
        hs_cyc.push_back(cyc);
      end
      if (prev_stall) begin
        total++;
        assert (bus.pix_vld === 1'b1 && bus.pix === prev_pix) else begin
          bad++;
          $error("FAIL hold: pix=%0d vld=%b expected pix=%0d vld=1", bus.pix, bus.pix_vld, prev_pix);
        end
      end
      prev_stall = bus.pix_vld && !bus.pix_rdy;
      prev_pix   = bus.pix;
      if (bus.done) begin
        done_n++;
        done_cyc     = cyc;
        busy_at_done = bus.busy;
      end
      if (bus.err) begin
        err_n++;
        err_cyc     = cyc;
        busy_at_err = bus.busy;
      end
    end else begin
      prev_stall = 1'b0;
    end
  end

  task automatic clear_mon();
    got_addr.delete();
    re_cyc.delete();
    got_pix.delete();
    hs_cyc.delete();
    done_n   = 0;
    err_n    = 0;
    done_cyc = -1;
    err_cyc  = -1;
    stall_re = 0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_raddr"},   32'(bus.raddr),   0);
    check({tag, "_re"},      32'(bus.re),      0);
    check({tag, "_pix"},     32'(bus.pix),     0);
    check({tag, "_pix_vld"}, 32'(bus.pix_vld), 0);
    check({tag, "_busy"},    32'(bus.busy),    0);
    check({tag, "_done"},    32'(bus.done),    0);
    check({tag, "_err"},     32'(bus.err),     0);
  endtask

  task automatic pulse_start(input int x, input int y, input int w, input int h);
    @(posedge clk);
    #1;
    bus.xloc  = xcoord_t'(x);
    bus.yloc  = ycoord_t'(y);
    bus.xwid  = xcoord_t'(w);
    bus.ywid  = ycoord_t'(h);
    bus.start = 1'b1;
  endtask

  // One request, start to completion, checked against the rectangle model.
  task automatic run_req(input int x, input int y, input int w, input int h,
                         input int mode, input int stall, input bit extra_start,
                         input string tag);
    int  exp_addr[$];
    int  st;
    int  n;
    bit  legal;
    legal = (w != 0) && (h != 0) && (x + w <= VID_W) && (y + h <= VID_H);
    if (legal) begin
      for (int r = 0; r < h; r++)
        for (int c = 0; c < w; c++)
          exp_addr.push_back((y + r) * VID_W + (x + c));
    end
    n = exp_addr.size();

    clear_mon();
    rdy_mode   = mode;
    stall_left = stall;
    pulse_start(x, y, w, h);
    st = cyc;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    // Scramble the request inputs: the block must work from its latched copy.
    bus.xloc  = xcoord_t'($urandom);
    bus.yloc  = ycoord_t'($urandom);
    bus.xwid  = xcoord_t'($urandom);
    bus.ywid  = ycoord_t'($urandom);
    check({tag, "_busy_chk"}, 32'(bus.busy), 1);

    if (extra_start) begin
      repeat (3) @(posedge clk);
      #1;
      bus.xloc  = 10'd0;
      bus.yloc  = 9'd0;
      bus.xwid  = 10'd7;
      bus.ywid  = 9'd3;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
    end

    for (int i = 0; i < 3000 && done_n == 0 && err_n == 0; i++) begin
      @(posedge clk);
      #1;
    end
    check({tag, "_finished"}, 32'(done_n + err_n), 1);
    repeat (4) @(posedge clk);
    #1;
    check({tag, "_busy_after"}, 32'(bus.busy), 0);

    if (legal) begin
      check({tag, "_done_n"},  32'(done_n), 1);
      check({tag, "_err_n"},   32'(err_n), 0);
      check({tag, "_re_n"},    32'(got_addr.size()), 32'(n));
      check({tag, "_pix_n"},   32'(got_pix.size()), 32'(n));
      for (int i = 0; i < n && i < got_addr.size(); i++)
        check({tag, $sformatf("_raddr%0d", i)}, 32'(got_addr[i]), 32'(exp_addr[i]));
      for (int i = 0; i < n && i < got_pix.size(); i++)
        check({tag, $sformatf("_pix%0d", i)}, 32'(got_pix[i]), 32'(pix_of(exp_addr[i])));
      if (re_cyc.size() > 0)
        check({tag, "_first_re_after_chk"}, 32'(re_cyc[0] >= st + 2), 1);
      if (hs_cyc.size() > 0)
        check({tag, "_done_cycle"}, 32'(done_cyc), 32'(hs_cyc[hs_cyc.size()-1] + 1));
      check({tag, "_busy_at_done"}, 32'(busy_at_done), 0);
      if (mode == 0) begin
        // re -> rdata -> pix start-up, then one pixel per cycle.
        if (re_cyc.size() > 0)
          check({tag, "_first_re_cycle"}, 32'(re_cyc[0]), 32'(st + 2));
        check({tag, "_done_latency"}, 32'(done_cyc), 32'(st + 4 + n));
      end
    end else begin
      check({tag, "_err_n"},       32'(err_n), 1);
      check({tag, "_done_n"},      32'(done_n), 0);
      check({tag, "_re_n"},        32'(got_addr.size()), 0);
      check({tag, "_err_cycle"},   32'(err_cyc), 32'(st + 2));
      check({tag, "_busy_at_err"}, 32'(busy_at_err), 0);
    end
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int w, h, x, y, m;
    bus.start = 1'b0;
    bus.xloc  = '0;
    bus.yloc  = '0;
    bus.xwid  = '0;
    bus.ywid  = '0;
    clear_mon();

    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Basic read: 1290,1291,1292,1930,1931,1932.
    run_req(10, 2, 3, 2, 0, 0, 1'b0, "basic");

    // Backpressure: consumer stalled for 5 cycles from the start pulse.
    run_req(10, 2, 3, 2, 2, 5, 1'b0, "bp");
    check("bp_re_during_stall_le2", 32'(stall_re <= 2), 1);

    // Bounds.
    run_req(630, 0, 11, 1, 0, 0, 1'b0, "x_over");
    run_req(630, 479, 10, 1, 0, 0, 1'b0, "corner");
    run_req(5, 470, 4, 11, 0, 0, 1'b0, "y_over");

    // Zero size.
    run_req(5, 5, 0, 3, 0, 0, 1'b0, "zero_w");
    run_req(5, 5, 3, 0, 0, 0, 1'b0, "zero_h");

    // Start while busy is ignored.
    run_req(20, 30, 5, 4, 1, 0, 1'b1, "busy_start");

    // Reset in the middle of a 4x4 read after 5 pixels, timed so that the
    // rdata of the last pre-reset read returns after reset is released.
    clear_mon();
    rdy_mode = 0;
    pulse_start(100, 50, 4, 4);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    for (int i = 0; i < 200 && got_pix.size() < 5; i++) begin
      @(posedge clk);
      #1;
    end
    check("midrst_reached5", 32'(got_pix.size() >= 5), 1);
    #5;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midrst_async");
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("midrst_after");
    run_req(200, 100, 4, 4, 0, 0, 1'b0, "post_rst");

    // Random rectangles, every third one pushed just past the right edge.
    for (int i = 0; i < 10; i++) begin
      w = $urandom_range(1, 6);
      h = $urandom_range(1, 4);
      x = $urandom_range(0, VID_W - w);
      y = $urandom_range(0, VID_H - h);
      if (i % 3 == 2) x = VID_W + 1 - w;
      m = $urandom_range(0, 1);
      run_req(x, y, w, h, m, 0, 1'b0, $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
